// File: rtl/control_cmd_dispatch_if.sv
// Byte-stream and handler handshake bundle between the UART front-end and the control handlers.
// The master drives received bytes and handler done flags; the slave is the command dispatcher.
interface control_cmd_dispatch_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] cmd_data;
  logic       wd_enable;
  logic       wd_done;
  logic       br_enable;
  logic       br_done;
  logic       busy;
  logic       cmd_error;
  logic       handler_abort;

  modport master (
    output rx_data, rx_valid, wd_done, br_done,
    input  cmd_data, wd_enable, br_enable, busy, cmd_error, handler_abort
  );

  modport slave (
    input  rx_data, rx_valid, wd_done, br_done,
    output cmd_data, wd_enable, br_enable, busy, cmd_error, handler_abort
  );
endinterface

// File: rtl/control_cmd_dispatch.sv
// Opcode-driven command router: forwards payload bytes to the watchdog or brightness handler,
// waits for that handler's done, and aborts commands that stall longer than TIMEOUT_TICKS.
module control_cmd_dispatch #(
  parameter int unsigned WATCHDOG_SIGNATURE_BITS = 32,
  parameter logic [7:0]  OPCODE_WATCHDOG         = 8'h57,
  parameter logic [7:0]  OPCODE_BRIGHTNESS       = 8'h42,
  parameter int unsigned BRIGHTNESS_BYTES        = 1,
  parameter int unsigned TIMEOUT_TICKS           = 100000
) (
  input logic                   clk,
  input logic                   reset,
  control_cmd_dispatch_if.slave bus
);

  localparam int unsigned WdBytes  = WATCHDOG_SIGNATURE_BITS / 8;
  localparam int unsigned MaxBytes = (WdBytes > BRIGHTNESS_BYTES) ? WdBytes : BRIGHTNESS_BYTES;
  localparam int unsigned RemW     = $clog2(MaxBytes + 1);
  localparam int unsigned TimerW   = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [RemW-1:0]   WdLen     = RemW'(WdBytes);
  localparam logic [RemW-1:0]   BrLen     = RemW'(BRIGHTNESS_BYTES);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_TICKS - 1);
  localparam logic [TimerW-1:0] TimerMax  = TimerW'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {StIdle, StPayload, StWaitDone} state_e;

  state_e              state_q;
  logic                sel_wd_q;
  logic [RemW-1:0]     rem_q;
  logic [TimerW-1:0]   timer_q;
  logic [7:0]          cmd_data_q;
  logic                wd_en_q;
  logic                br_en_q;
  logic                busy_q;
  logic                err_q;
  logic                abort_q;

  logic                timer_hit;
  logic [TimerW-1:0]   timer_inc;
  logic                sel_done;

  // The cycle that would bring the count to TIMEOUT_TICKS is the one that fires the abort.
  assign timer_hit = (timer_q >= TimerLast);
  assign timer_inc = (timer_q == TimerMax) ? timer_q : timer_q + TimerW'(1);
  assign sel_done  = sel_wd_q ? bus.wd_done : bus.br_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sel_wd_q   <= 1'b0;
      rem_q      <= '0;
      timer_q    <= '0;
      cmd_data_q <= '0;
      wd_en_q    <= 1'b0;
      br_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      wd_en_q <= 1'b0;
      br_en_q <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        StIdle: begin
          timer_q <= '0;
          if (bus.rx_valid) begin
            if (bus.rx_data == OPCODE_WATCHDOG) begin
              sel_wd_q <= 1'b1;
              rem_q    <= WdLen;
              state_q  <= StPayload;
              busy_q   <= 1'b1;
            end else if (bus.rx_data == OPCODE_BRIGHTNESS) begin
              sel_wd_q <= 1'b0;
              rem_q    <= BrLen;
              state_q  <= StPayload;
              busy_q   <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StPayload: begin
          // An arriving byte wins over a coincident timeout.
          if (bus.rx_valid) begin
            cmd_data_q <= bus.rx_data;
            wd_en_q    <= sel_wd_q;
            br_en_q    <= ~sel_wd_q;
            rem_q      <= rem_q - RemW'(1);
            timer_q    <= '0;
            if (rem_q == RemW'(1)) begin
              state_q <= StWaitDone;
            end
          end else if (timer_hit) begin
            err_q   <= 1'b1;
            abort_q <= 1'b1;
            timer_q <= '0;
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_inc;
          end
        end
        StWaitDone: begin
          if (bus.rx_valid) begin
            err_q <= 1'b1;
          end
          if (sel_done) begin
            timer_q <= '0;
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (timer_hit) begin
            err_q   <= 1'b1;
            abort_q <= 1'b1;
            timer_q <= '0;
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_inc;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_data      = cmd_data_q;
  assign bus.wd_enable     = wd_en_q;
  assign bus.br_enable     = br_en_q;
  assign bus.busy          = busy_q;
  assign bus.cmd_error     = err_q;
  assign bus.handler_abort = abort_q;

endmodule

// File: tb/tb_control_cmd_dispatch.sv
// Directed cycle checks followed by randomized commands scored against a transaction-level model.
module tb_control_cmd_dispatch;

  localparam int unsigned Timeout = 16;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  control_cmd_dispatch_if bus_if ();

  control_cmd_dispatch #(
    .WATCHDOG_SIGNATURE_BITS(32),
    .OPCODE_WATCHDOG        (8'h57),
    .OPCODE_BRIGHTNESS      (8'h42),
    .BRIGHTNESS_BYTES       (1),
    .TIMEOUT_TICKS          (Timeout)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction monitor: {1=watchdog/0=brightness, byte} per enable pulse, plus pulse counts.
  logic [8:0] obs_q[$];
  int         err_cnt;
  int         abort_cnt;

  initial begin
    err_cnt   = 0;
    abort_cnt = 0;
  end

  always @(negedge clk) begin
    if (bus_if.wd_enable) obs_q.push_back({1'b1, bus_if.cmd_data});
    if (bus_if.br_enable) obs_q.push_back({1'b0, bus_if.cmd_data});
    if (bus_if.cmd_error) err_cnt = err_cnt + 1;
    if (bus_if.handler_abort) abort_cnt = abort_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    tick();
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic chk_outputs(input string tag, input logic [7:0] data, input logic wd,
                             input logic br, input logic busy, input logic err, input logic abt);
    chk({tag, ".cmd_data"}, 32'(bus_if.cmd_data), 32'(data));
    chk({tag, ".wd_enable"}, 32'(bus_if.wd_enable), 32'(wd));
    chk({tag, ".br_enable"}, 32'(bus_if.br_enable), 32'(br));
    chk({tag, ".busy"}, 32'(bus_if.busy), 32'(busy));
    chk({tag, ".cmd_error"}, 32'(bus_if.cmd_error), 32'(err));
    chk({tag, ".abort"}, 32'(bus_if.handler_abort), 32'(abt));
  endtask

  // Model: a command forwards its payload bytes in order to the opcode's handler; an unknown
  // opcode costs one error; silence for Timeout cycles costs one error and one abort.
  task automatic run_random_cmd(input int idx);
    int         kind;
    int         len;
    int         nsend;
    bit         is_wd;
    bit         stall;
    logic [7:0] op;
    logic [7:0] b;
    logic [8:0] exp_q[$];
    int         exp_err;
    int         exp_abort;
    int         obs_base;
    int         err_base;
    int         abort_base;

    obs_base   = obs_q.size();
    err_base   = err_cnt;
    abort_base = abort_cnt;
    exp_err    = 0;
    exp_abort  = 0;
    kind       = int'($urandom_range(0, 3));

    if (kind == 3) begin
      do op = 8'($urandom); while (op == 8'h57 || op == 8'h42);
      send_byte(op);
      tick();
      exp_err = 1;
    end else begin
      is_wd = (kind != 2);
      len   = is_wd ? 4 : 1;
      stall = ($urandom_range(0, 4) == 0);
      nsend = stall ? int'($urandom_range(0, len - 1)) : len;
      send_byte(is_wd ? 8'h57 : 8'h42);
      for (int i = 0; i < nsend; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        b = 8'($urandom);
        send_byte(b);
        exp_q.push_back({is_wd, b});
      end
      if (stall) begin
        repeat (Timeout + 4) tick();
        exp_err   = 1;
        exp_abort = 1;
      end else begin
        repeat ($urandom_range(0, 4)) tick();
        if ($urandom_range(0, 1) == 1) begin
          if (is_wd) bus_if.br_done = 1'b1;
          else bus_if.wd_done = 1'b1;
          tick();
          bus_if.br_done = 1'b0;
          bus_if.wd_done = 1'b0;
        end
        if (is_wd) bus_if.wd_done = 1'b1;
        else bus_if.br_done = 1'b1;
        tick();
        bus_if.wd_done = 1'b0;
        bus_if.br_done = 1'b0;
      end
    end
    tick();

    chk($sformatf("rnd%0d.count", idx), 32'(obs_q.size() - obs_base), 32'(exp_q.size()));
    if (obs_q.size() - obs_base == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        chk($sformatf("rnd%0d.fwd%0d", idx, i), 32'(obs_q[obs_base + i]), 32'(exp_q[i]));
      end
    end
    chk($sformatf("rnd%0d.errors", idx), 32'(err_cnt - err_base), 32'(exp_err));
    chk($sformatf("rnd%0d.aborts", idx), 32'(abort_cnt - abort_base), 32'(exp_abort));
    chk($sformatf("rnd%0d.idle", idx), 32'(bus_if.busy), 32'd0);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    bus_if.rx_data  = 8'h00;
    bus_if.rx_valid = 1'b0;
    bus_if.wd_done  = 1'b0;
    bus_if.br_done  = 1'b0;
    tick();
    tick();
    chk_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();

    // Watchdog command, bytes back to back.
    send_byte(8'h57);
    chk_outputs("wd.op", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'hDE);
    chk_outputs("wd.b0", 8'hDE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'hAD);
    chk_outputs("wd.b1", 8'hAD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'hBE);
    chk_outputs("wd.b2", 8'hBE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'hEF);
    chk_outputs("wd.b3", 8'hEF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_outputs("wd.wait", 8'hEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus_if.wd_done = 1'b1;
    tick();
    bus_if.wd_done = 1'b0;
    chk_outputs("wd.done", 8'hEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Brightness command; opcode arrives on the first idle cycle.
    send_byte(8'h42);
    chk("br.op.busy", 32'(bus_if.busy), 32'd1);
    send_byte(8'h80);
    chk_outputs("br.b0", 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus_if.wd_done = 1'b1;
    tick();
    bus_if.wd_done = 1'b0;
    chk("br.wrong_done.busy", 32'(bus_if.busy), 32'd1);
    bus_if.br_done = 1'b1;
    tick();
    bus_if.br_done = 1'b0;
    chk("br.done.busy", 32'(bus_if.busy), 32'd0);

    // Unknown opcode.
    send_byte(8'h13);
    chk_outputs("unk", 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("unk.pulse_end", 32'(bus_if.cmd_error), 32'd0);

    // Stall after one payload byte.
    send_byte(8'h57);
    send_byte(8'hDE);
    chk("to.fwd", 32'(bus_if.wd_enable), 32'd1);
    repeat (Timeout - 1) tick();
    chk_outputs("to.before", 8'hDE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_outputs("to.fire", 8'hDE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_outputs("to.after", 8'hDE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fresh command after timeout, then a byte dropped while waiting for done.
    send_byte(8'h57);
    chk("fresh.busy", 32'(bus_if.busy), 32'd1);
    send_byte(8'h11);
    chk_outputs("fresh.b0", 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    chk("fresh.b3", 32'(bus_if.cmd_data), 32'h44);
    send_byte(8'h55);
    chk_outputs("drop", 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_outputs("drop.after", 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Done and a byte together: byte dropped with error, then idle.
    bus_if.wd_done = 1'b1;
    send_byte(8'h66);
    bus_if.wd_done = 1'b0;
    chk_outputs("done_rx", 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset between payload bytes discards the command silently.
    send_byte(8'h57);
    send_byte(8'h77);
    reset = 1'b1;
    tick();
    chk_outputs("midrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    send_byte(8'h42);
    chk_outputs("midrst.op", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h33);
    chk_outputs("midrst.b0", 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus_if.br_done = 1'b1;
    tick();
    bus_if.br_done = 1'b0;
    chk("midrst.done", 32'(bus_if.busy), 32'd0);

    for (int n = 0; n < 40; n++) begin
      run_random_cmd(n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
